// File: rtl/ibex_register_file_mp.sv
// rtl/ibex_register_file_mp.sv - multi-port flop register file with bypass, clear sequencer and conflict flag
module ibex_register_file_mp #(
    parameter bit                    RV32E         = 1'b0,
    parameter int                    DataWidth     = 32,
    parameter int                    NumReadPorts  = 2,
    parameter int                    NumWritePorts = 1,
    parameter bit                    Bypass        = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal   = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [5*NumReadPorts-1:0]         raddr_i,
    output logic [DataWidth*NumReadPorts-1:0] rdata_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    input  logic [4:0]                        waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              we_b_i,
    input  logic                              clr_req_i,
    output logic                              clr_busy_o,
    output logic                              err_o
);

    localparam int         NUM_WORDS = RV32E ? 16 : 32;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_WORDS - 1);

    // RV32E drops address bit 4 so upper addresses alias onto 0..15
    function automatic logic [4:0] map_addr(input logic [4:0] a);
        return RV32E ? {1'b0, a[3:0]} : a;
    endfunction

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e               state_q, state_d;
    logic [4:0]           clr_idx_q, clr_idx_d;
    logic                 clr_we;
    logic                 idle;
    logic                 err_q;
    logic [4:0]           wa, wb;
    logic                 we_a_eff, we_b_eff, conflict;
    logic [DataWidth-1:0] mem_q [1:NUM_WORDS-1];
    logic [DataWidth-1:0] words [32];
    logic [4:0]           rd_addr [NumReadPorts];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clr_idx_q <= 5'd1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d   = CLEAR;
                    clr_idx_d = 5'd1;
                end
            end
            CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = IDLE;
                    clr_idx_d = 5'd1;
                end else begin
                    clr_idx_d = clr_idx_q + 5'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_idx_d = 5'd1;
            end
        endcase
    end

    always_comb begin
        clr_busy_o = (state_q == CLEAR);
        clr_we     = (state_q == CLEAR);
        idle       = (state_q == IDLE);
    end

    // Write ports only act while idle; word 0 writes are discarded
    always_comb begin
        wa       = map_addr(waddr_a_i);
        wb       = map_addr(waddr_b_i);
        we_a_eff = idle && we_a_i && (wa != 5'd0);
        we_b_eff = (NumWritePorts == 2) && idle && we_b_i && (wb != 5'd0);
        conflict = we_a_eff && we_b_eff && (wa == wb);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 1; w < NUM_WORDS; w++) begin
                mem_q[w] <= WordZeroVal;
            end
        end else begin
            for (int w = 1; w < NUM_WORDS; w++) begin
                if (clr_we && clr_idx_q == 5'(w)) begin
                    mem_q[w] <= WordZeroVal;
                end else if (we_b_eff && wb == 5'(w)) begin
                    mem_q[w] <= wdata_b_i;
                end else if (we_a_eff && wa == 5'(w)) begin
                    mem_q[w] <= wdata_a_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (conflict) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    always_comb begin
        for (int w = 0; w < 32; w++) begin
            words[w] = WordZeroVal;
        end
        for (int w = 1; w < NUM_WORDS; w++) begin
            words[w] = mem_q[w];
        end
    end

    // Port B is the younger instruction, so its forward overrides port A
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            rd_addr[p] = map_addr(raddr_i[5*p +: 5]);
            rdata_o[DataWidth*p +: DataWidth] = words[rd_addr[p]];
            if (Bypass && idle && rd_addr[p] != 5'd0) begin
                if (we_a_eff && wa == rd_addr[p]) begin
                    rdata_o[DataWidth*p +: DataWidth] = wdata_a_i;
                end
                if (we_b_eff && wb == rd_addr[p]) begin
                    rdata_o[DataWidth*p +: DataWidth] = wdata_b_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb/tb_ibex_register_file_mp.sv - directed bench for two register file configurations
module tb_ibex_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [9:0]  raddr = '0;
    logic [4:0]  waddr_a = '0, waddr_b = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0, clr_req = 1'b0;
    logic [63:0] rdata0, rdata1;
    logic        busy0, busy1, err0, err1;
    int          passes = 0;
    int          checks = 0;
    int          n0, n1;

    // dut0: 32 words, no bypass; dut1: RV32E with bypass; both two write ports
    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2), .Bypass(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata0),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .clr_req_i(clr_req), .clr_busy_o(busy0), .err_o(err0)
    );

    ibex_register_file_mp #(
        .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2), .Bypass(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata1),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .clr_req_i(clr_req), .clr_busy_o(busy1), .err_o(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_run(input bit with_write, output int c0, output int c1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            if (with_write && i == 4) begin
                waddr_a = 5'd2;
                wdata_a = 32'h99;
                we_a    = 1'b1;
            end else begin
                we_a = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        #2;
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        #10;
        rst_ni = 1'b1;
        tick();

        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            chk("rst_rd0_p0", rdata0[31:0], 32'h0);
            chk("rst_rd0_p1", rdata0[63:32], 32'h0);
            chk("rst_rd1_p0", rdata1[31:0], 32'h0);
            chk("rst_rd1_p1", rdata1[63:32], 32'h0);
        end

        waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; we_a = 1'b1;
        raddr = {5'd0, 5'd5};
        #1;
        chk("wr_same_nobyp", rdata0[31:0], 32'h0);
        chk("wr_same_byp", rdata1[31:0], 32'hDEADBEEF);
        tick();
        we_a = 1'b0;
        #1;
        chk("wr_next_nobyp", rdata0[31:0], 32'hDEADBEEF);
        chk("wr_next_byp", rdata1[31:0], 32'hDEADBEEF);

        waddr_a = 5'd7; wdata_a = 32'h11; we_a = 1'b1;
        waddr_b = 5'd7; wdata_b = 32'h22; we_b = 1'b1;
        raddr = {5'd0, 5'd7};
        #1;
        chk("conf_same_nobyp", rdata0[31:0], 32'h0);
        chk("conf_same_byp_b", rdata1[31:0], 32'h22);
        chk("conf_err_before", 32'(err0), 32'd0);
        tick();
        we_a = 1'b0; we_b = 1'b0;
        #1;
        chk("conf_rd0", rdata0[31:0], 32'h22);
        chk("conf_rd1", rdata1[31:0], 32'h22);
        chk("conf_err0", 32'(err0), 32'd1);
        chk("conf_err1", 32'(err1), 32'd1);
        tick();
        tick();
        chk("conf_err0_sticky", 32'(err0), 32'd1);

        waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; we_a = 1'b1;
        raddr = {5'd0, 5'd0};
        #1;
        chk("w0_byp_blocked", rdata1[31:0], 32'h0);
        tick();
        we_a = 1'b0;
        #1;
        chk("w0_rd0", rdata0[31:0], 32'h0);
        chk("w0_rd1", rdata1[31:0], 32'h0);

        waddr_a = 5'h13; wdata_a = 32'hAB; we_a = 1'b1;
        tick();
        we_a = 1'b0;
        raddr = {5'h13, 5'd3};
        #1;
        chk("e_alias_rd3", rdata1[31:0], 32'hAB);
        chk("e_alias_rd19", rdata1[63:32], 32'hAB);
        chk("full_rd19", rdata0[63:32], 32'hAB);
        chk("full_rd3", rdata0[31:0], 32'h0);

        for (int i = 1; i < 32; i++) begin
            waddr_a = 5'(i); wdata_a = 32'(i); we_a = 1'b1;
            tick();
        end
        we_a = 1'b0;
        raddr = {5'd20, 5'd4};
        #1;
        chk("fill_rd0_4", rdata0[31:0], 32'd4);
        chk("fill_rd0_20", rdata0[63:32], 32'd20);
        chk("fill_rd1_4", rdata1[31:0], 32'd20);
        chk("fill_rd1_20", rdata1[63:32], 32'd20);

        clear_run(1'b1, n0, n1);
        chk("clr_busy_cycles0", 32'(n0), 32'd31);
        chk("clr_busy_cycles1", 32'(n1), 32'd15);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            chk("clr_rd0", rdata0[31:0], 32'h0);
            chk("clr_rd1", rdata1[31:0], 32'h0);
        end

        waddr_a = 5'd30; wdata_a = 32'h30; we_a = 1'b1;
        tick();
        we_a = 1'b0;
        raddr = {5'd14, 5'd30};
        #1;
        chk("pre_rd0_30", rdata0[31:0], 32'h30);
        chk("pre_rd1_14", rdata1[63:32], 32'h30);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy0", 32'(busy0), 32'd1);
        chk("mid_err0", 32'(err0), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mrst_busy0", 32'(busy0), 32'd0);
        chk("mrst_busy1", 32'(busy1), 32'd0);
        chk("mrst_err0", 32'(err0), 32'd0);
        chk("mrst_err1", 32'(err1), 32'd0);
        chk("mrst_rd0_30", rdata0[31:0], 32'h0);
        chk("mrst_rd1_14", rdata1[63:32], 32'h0);
        rst_ni = 1'b1;
        tick();

        clear_run(1'b0, n0, n1);
        chk("reclr_busy_cycles0", 32'(n0), 32'd31);
        chk("reclr_busy_cycles1", 32'(n1), 32'd15);
        chk("reclr_err0", 32'(err0), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
